// File: rtl/tcam_pkg.sv
// rtl/tcam_pkg.sv - shared constants and types for the TCAM match encoder
package tcam_pkg;

  localparam int TCAM_ROWS   = 64;
  localparam int TCAM_ADDR_W = 6;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } enc_state_e;

  typedef logic [TCAM_ROWS-1:0] match_vec_t;

endpackage

// File: rtl/tcam_prio_enc64.sv
// rtl/tcam_prio_enc64.sv - 64-bit lowest-set-bit priority encoder, two-level 8x8 tree
module tcam_prio_enc64
  import tcam_pkg::*;
(
  input  match_vec_t             vec_i,
  output logic [TCAM_ADDR_W-1:0] addr_o,
  output logic                   none_o,
  output logic                   single_o
);

  logic [7:0] grp_any;
  logic [7:0] grp_single;
  logic [2:0] grp_low [8];
  logic [2:0] grp_sel;
  logic [7:0] byte_v;

  // First level: per-byte lowest set bit and at-most-one-bit flag.
  always_comb begin
    byte_v = '0;
    for (int g = 0; g < 8; g++) begin
      byte_v        = vec_i[g*8 +: 8];
      grp_any[g]    = |byte_v;
      grp_single[g] = ((byte_v & (byte_v - 8'd1)) == 8'd0);
      grp_low[g]    = '0;
      for (int b = 7; b >= 0; b--) begin
        if (byte_v[b]) grp_low[g] = 3'(b);
      end
    end
  end

  // Second level: lowest non-empty byte wins.
  always_comb begin
    grp_sel = '0;
    for (int g = 7; g >= 0; g--) begin
      if (grp_any[g]) grp_sel = 3'(g);
    end
  end

  assign addr_o   = {grp_sel, grp_low[grp_sel]};
  assign none_o   = ~|grp_any;
  assign single_o = (&grp_single) & ((grp_any & (grp_any - 8'd1)) == 8'd0);

endmodule

// File: rtl/tcam_match_encoder.sv
// rtl/tcam_match_encoder.sv - resolves TCAM match vectors into prioritised row addresses
module tcam_match_encoder
  import tcam_pkg::*;
#(
  parameter int MATCH_W = TCAM_ROWS,
  parameter int ADDR_W  = TCAM_ADDR_W,
  parameter int RD_LAT  = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               search_valid_i,
  input  logic               all_matches_i,
  input  logic [MATCH_W-1:0] rdata_i,
  output logic               match_valid_o,
  input  logic               match_ready_i,
  output logic [ADDR_W-1:0]  match_addr_o,
  output logic               match_none_o,
  output logic               match_last_o,
  output logic               busy_o,
  output logic               overflow_o
);

  enc_state_e  state_q, state_d;
  match_vec_t  pending_q, pending_d;
  logic        mode_q, mode_d;
  logic        overflow_q;
  logic [RD_LAT-1:0] dly_vld_q;
  logic [RD_LAT-1:0] dly_mode_q;

  logic [TCAM_ADDR_W-1:0] enc_addr;
  logic                   enc_none;
  logic                   enc_single;

  logic              valid_c;
  logic [ADDR_W-1:0] addr_c;
  logic              none_c;
  logic              last_c;

  tcam_prio_enc64 u_prio_enc (
    .vec_i    (pending_q),
    .addr_o   (enc_addr),
    .none_o   (enc_none),
    .single_o (enc_single)
  );

  assign busy_o = (state_q != IDLE) | (|dly_vld_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      mode_q     <= 1'b0;
      overflow_q <= 1'b0;
      dly_vld_q  <= '0;
      dly_mode_q <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      mode_q        <= mode_d;
      // Searches issued while busy never enter the pipeline.
      overflow_q    <= search_valid_i & busy_o;
      dly_vld_q[0]  <= search_valid_i & ~busy_o;
      dly_mode_q[0] <= all_matches_i;
      for (int i = 1; i < RD_LAT; i++) begin
        dly_vld_q[i]  <= dly_vld_q[i-1];
        dly_mode_q[i] <= dly_mode_q[i-1];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    mode_d    = mode_q;
    valid_c   = 1'b0;
    addr_c    = '0;
    none_c    = 1'b0;
    last_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (dly_vld_q[RD_LAT-1]) begin
          pending_d = rdata_i;
          mode_d    = dly_mode_q[RD_LAT-1];
          state_d   = EMIT;
        end
      end
      EMIT: begin
        valid_c = 1'b1;
        addr_c  = ADDR_W'(enc_addr);
        none_c  = enc_none;
        last_c  = enc_none | ~mode_q | enc_single;
        if (match_ready_i) begin
          if (last_c) begin
            state_d   = IDLE;
            pending_d = '0;
          end else begin
            pending_d[enc_addr] = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign match_valid_o = valid_c;
  assign match_addr_o  = addr_c;
  assign match_none_o  = none_c;
  assign match_last_o  = last_c;
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_tcam_match_encoder.sv
// tb/tb_tcam_match_encoder.sv - directed self-checking bench for tcam_match_encoder
module tb_tcam_match_encoder;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        search_valid_i = 1'b0;
  logic        all_matches_i = 1'b0;
  logic [63:0] rdata_i = '0;
  logic        match_valid_o;
  logic        match_ready_i = 1'b0;
  logic [5:0]  match_addr_o;
  logic        match_none_o;
  logic        match_last_o;
  logic        busy_o;
  logic        overflow_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  tcam_match_encoder #(.MATCH_W(64), .ADDR_W(6), .RD_LAT(1)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .search_valid_i (search_valid_i),
    .all_matches_i  (all_matches_i),
    .rdata_i        (rdata_i),
    .match_valid_o  (match_valid_o),
    .match_ready_i  (match_ready_i),
    .match_addr_o   (match_addr_o),
    .match_none_o   (match_none_o),
    .match_last_o   (match_last_o),
    .busy_o         (busy_o),
    .overflow_o     (overflow_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Issue a search; vector is presented one cycle later, then replaced by junk.
  task automatic issue(input logic mode, input logic [63:0] vec);
    search_valid_i = 1'b1;
    all_matches_i  = mode;
    step();
    search_valid_i = 1'b0;
    all_matches_i  = 1'b0;
    rdata_i        = vec;
    step();
    rdata_i        = 64'hFFFF_FFFF_FFFF_FFFF;
  endtask

  task automatic expect_result(input string name, input logic [5:0] addr,
                               input logic none, input logic last);
    checks++;
    if (match_valid_o !== 1'b1 || match_addr_o !== addr ||
        match_none_o !== none || match_last_o !== last) begin
      failures++;
      $display("FAIL %s: got valid=%b addr=%0d none=%b last=%b want valid=1 addr=%0d none=%b last=%b",
               name, match_valid_o, match_addr_o, match_none_o, match_last_o, addr, none, last);
    end
  endtask

  task automatic expect_idle(input string name);
    checks++;
    if (match_valid_o !== 1'b0 || busy_o !== 1'b0 || match_addr_o !== 6'd0 ||
        match_none_o !== 1'b0 || match_last_o !== 1'b0) begin
      failures++;
      $display("FAIL %s: got valid=%b busy=%b addr=%0d none=%b last=%b want all 0",
               name, match_valid_o, busy_o, match_addr_o, match_none_o, match_last_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    expect_idle("reset_outputs");
    checks++;
    if (overflow_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_overflow: got %b want 0", overflow_o);
    end
  endtask

  task automatic test_single();
    match_ready_i = 1'b0;
    search_valid_i = 1'b1;
    all_matches_i  = 1'b0;
    step();
    search_valid_i = 1'b0;
    rdata_i = 64'h0000_0000_0000_0120;
    checks++;
    if (busy_o !== 1'b1 || match_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL single_inflight: got busy=%b valid=%b want busy=1 valid=0", busy_o, match_valid_o);
    end
    step();
    rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
    expect_result("single_addr5", 6'd5, 1'b0, 1'b1);
    match_ready_i = 1'b1;
    step();
    expect_idle("single_done");
  endtask

  task automatic test_all_matches();
    logic [5:0] exp_addr [4];
    logic       exp_last [4];
    exp_addr = '{6'd0, 6'd1, 6'd16, 6'd63};
    exp_last = '{1'b0, 1'b0, 1'b0, 1'b1};
    match_ready_i = 1'b1;
    issue(1'b1, 64'h8000_0000_0001_0003);
    for (int i = 0; i < 4; i++) begin
      expect_result($sformatf("all_hit%0d", i), exp_addr[i], 1'b0, exp_last[i]);
      step();
    end
    expect_idle("all_done");
  endtask

  task automatic test_no_hit();
    match_ready_i = 1'b1;
    issue(1'b1, 64'h0);
    expect_result("none_result", 6'd0, 1'b1, 1'b1);
    step();
    expect_idle("none_done");
  endtask

  task automatic test_backpressure();
    match_ready_i = 1'b0;
    issue(1'b1, 64'h0000_0000_0000_0C00);
    expect_result("bp_first", 6'd10, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      search_valid_i = (i == 0);
      all_matches_i  = 1'b0;
      if (i == 1) rdata_i = 64'h1;
      step();
      search_valid_i = 1'b0;
      expect_result($sformatf("bp_hold%0d", i), 6'd10, 1'b0, 1'b0);
      checks++;
      if (overflow_o !== (i == 0)) begin
        failures++;
        $display("FAIL bp_overflow%0d: got %b want %b", i, overflow_o, (i == 0));
      end
    end
    rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
    match_ready_i = 1'b1;
    step();
    expect_result("bp_second", 6'd11, 1'b0, 1'b1);
    step();
    expect_idle("bp_done");
    step();
    step();
    expect_idle("bp_dropped_search");
  endtask

  task automatic test_reset_mid();
    match_ready_i = 1'b1;
    issue(1'b1, 64'h0000_0000_0000_00F0);
    expect_result("rst_hit0", 6'd4, 1'b0, 1'b0);
    step();
    expect_result("rst_hit1", 6'd5, 1'b0, 1'b0);
    step();
    expect_result("rst_hit2", 6'd6, 1'b0, 1'b0);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    expect_idle("rst_cleared");
    issue(1'b1, 64'h0000_0000_0000_0300);
    expect_result("rst_fresh0", 6'd8, 1'b0, 1'b0);
    step();
    expect_result("rst_fresh1", 6'd9, 1'b0, 1'b1);
    step();
    expect_idle("rst_fresh_done");
  endtask

  task automatic test_edges();
    match_ready_i = 1'b1;
    issue(1'b0, 64'h8000_0000_0000_0000);
    expect_result("edge_row63", 6'd63, 1'b0, 1'b1);
    step();
    expect_idle("edge_row63_done");
    issue(1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    expect_result("edge_allones_single", 6'd0, 1'b0, 1'b1);
    step();
    expect_idle("edge_allones_done");
    issue(1'b1, 64'h8000_0000_0000_0000);
    expect_result("edge_row63_all", 6'd63, 1'b0, 1'b1);
    step();
    expect_idle("edge_row63_all_done");
  endtask

  task automatic test_back_to_back();
    match_ready_i = 1'b1;
    issue(1'b0, 64'h0000_0000_0000_0080);
    expect_result("b2b_first", 6'd7, 1'b0, 1'b1);
    step();
    issue(1'b0, 64'h0000_0000_0000_0006);
    expect_result("b2b_second", 6'd1, 1'b0, 1'b1);
    step();
    expect_idle("b2b_done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_matches();
    test_no_hit();
    test_backpressure();
    test_reset_mid();
    test_edges();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
